// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Display and buzzer stage that follows the countdown timer core.
//   The six BCD digits are latched once per display frame, so a frame never
//   shows a mixture of old and new time values. The latched digits drive a
//   six-digit multiplexed seven-segment display, one digit per scan slot.
//   A rising edge on `done` starts a fixed-length square-wave beep.
//
//   Optional build macro: LEADING_ZERO_BLANK_EN
//     When defined, a zero hours-tens digit is blanked. The hours-units digit
//     is also blanked when both hours digits are zero. The decimal point after
//     the hours-units digit stays lit.
//
// Parameters
//   SCAN_DIV  clk cycles per digit slot (>= 2)
//   BEEP_LEN  clk cycles the buzzer runs after a done edge (>= 1)
//   TONE_DIV  clk cycles per half-period of the buzzer tone (>= 1)
//
// Ports
//   clk        system clock
//   clr        synchronous active-high reset; overrides all other activity
//   H_h..S_l   BCD digits from the timer core (hours tens .. seconds units)
//   done       timer-expired level from the countdown core
//   seg        segments {g,f,e,d,c,b,a}, active-high
//   an         digit enables, active-low; an[0]=S_l .. an[5]=H_h
//   dp         decimal point, active-high (lit on slots 2 and 4)
//   buzz       buzzer drive
module seg_scan_driver #(
    parameter int SCAN_DIV = 50000,
    parameter int BEEP_LEN = 25000000,
    parameter int TONE_DIV = 12500
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] H_h,
    input  logic [3:0] H_l,
    input  logic [3:0] M_h,
    input  logic [3:0] M_l,
    input  logic [3:0] S_h,
    input  logic [3:0] S_l,
    input  logic       done,
    output logic [6:0] seg,
    output logic [5:0] an,
    output logic       dp,
    output logic       buzz
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BEEP_LEN + 1);
    localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    // ------------------------------------------------------------------
    // Seven-segment decode; codes 10-15 are blanked
    // ------------------------------------------------------------------
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Scan state
    // ------------------------------------------------------------------
    logic [PW-1:0] prescaler;
    logic [2:0]    index;
    logic [3:0]    snap_h_h, snap_h_l, snap_m_h, snap_m_l, snap_s_h, snap_s_l;

    logic          tick;
    logic [2:0]    next_index;
    logic [3:0]    next_digit;
    logic          next_blank;
    logic [6:0]    next_seg;
    logic [5:0]    next_an;
    logic          next_dp;

    assign tick = (prescaler == PW'(SCAN_DIV - 1));

    always_comb begin
        next_index = (index == 3'd5) ? 3'd0 : index + 3'd1;
        next_digit = 4'd0;
        next_blank = 1'b0;

        // Slot 0 is only entered from slot 5, which is the capture edge, so
        // the live S_l is exactly the value being latched into the snapshot.
        case (next_index)
            3'd0:    next_digit = S_l;
            3'd1:    next_digit = snap_s_h;
            3'd2:    next_digit = snap_m_l;
            3'd3:    next_digit = snap_m_h;
            3'd4:    next_digit = snap_h_l;
            3'd5:    next_digit = snap_h_h;
            default: next_digit = 4'd0;
        endcase

`ifdef LEADING_ZERO_BLANK_EN
        if (next_index == 3'd5 && snap_h_h == 4'd0)
            next_blank = 1'b1;
        if (next_index == 3'd4 && snap_h_h == 4'd0 && snap_h_l == 4'd0)
            next_blank = 1'b1;
`else
        next_blank = 1'b0;
`endif

        next_seg = next_blank ? 7'h00 : decode(next_digit);
        next_an  = ~(6'b000001 << next_index);
        next_dp  = (next_index == 3'd2) || (next_index == 3'd4);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            prescaler <= '0;
            index     <= 3'd5;
            snap_h_h  <= 4'd0;
            snap_h_l  <= 4'd0;
            snap_m_h  <= 4'd0;
            snap_m_l  <= 4'd0;
            snap_s_h  <= 4'd0;
            snap_s_l  <= 4'd0;
            seg       <= 7'h00;
            an        <= 6'b111111;
            dp        <= 1'b0;
        end else if (tick) begin
            prescaler <= '0;
            index     <= next_index;
            if (index == 3'd5) begin
                snap_h_h <= H_h;
                snap_h_l <= H_l;
                snap_m_h <= M_h;
                snap_m_l <= M_l;
                snap_s_h <= S_h;
                snap_s_l <= S_l;
            end
            seg <= next_seg;
            an  <= next_an;
            dp  <= next_dp;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Beep generator
    // ------------------------------------------------------------------
    logic          done_d;
    logic [BW-1:0] beep_cnt;
    logic [TW-1:0] tone_cnt;

    always_ff @(posedge clk) begin
        if (clr) begin
            done_d   <= 1'b0;
            beep_cnt <= '0;
            tone_cnt <= '0;
            buzz     <= 1'b0;
        end else begin
            done_d <= done;
            if (done && !done_d) begin
                // A new edge always restarts at full length, even mid-beep.
                beep_cnt <= BW'(BEEP_LEN);
                tone_cnt <= '0;
                buzz     <= 1'b0;
            end else if (beep_cnt != '0) begin
                beep_cnt <= beep_cnt - BW'(1);
                if (beep_cnt == BW'(1)) begin
                    // Last active cycle: leave the buzzer quiet.
                    tone_cnt <= '0;
                    buzz     <= 1'b0;
                end else if (tone_cnt == TW'(TONE_DIV - 1)) begin
                    tone_cnt <= '0;
                    buzz     <= ~buzz;
                end else begin
                    tone_cnt <= tone_cnt + TW'(1);
                end
            end else begin
                tone_cnt <= '0;
                buzz     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver
//   Bench for seg_scan_driver with a short scan period and beep. A reference
//   model counts clock edges since reset. It derives the active slot, the
//   frame snapshot and the beep phase from those counts. It honours
//   LEADING_ZERO_BLANK_EN when the macro is defined for the build.
module tb_seg_scan_driver;

  localparam int SCAN_DIV = 4;
  localparam int BEEP_LEN = 10;
  localparam int TONE_DIV = 2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [3:0] h_h = 4'd0, h_l = 4'd0, m_h = 4'd0, m_l = 4'd0, s_h = 4'd0, s_l = 4'd0;
  logic       done = 1'b0;
  logic [6:0] seg;
  logic [5:0] an;
  logic       dp;
  logic       buzz;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .SCAN_DIV(SCAN_DIV),
    .BEEP_LEN(BEEP_LEN),
    .TONE_DIV(TONE_DIV)
  ) dut (
    .clk (clk),
    .clr (clr),
    .H_h (h_h),
    .H_l (h_l),
    .M_h (m_h),
    .M_l (m_l),
    .S_h (s_h),
    .S_l (s_l),
    .done(done),
    .seg (seg),
    .an  (an),
    .dp  (dp),
    .buzz(buzz)
  );

  // ---------------- reference model ----------------
  logic [6:0] seg_tbl [16];
  logic [3:0] m_snap [6];
  int         m_n;
  int         m_slot;
  bit         m_ticked;
  logic [6:0] m_seg;
  logic [5:0] m_an;
  logic       m_dp;
  bit         m_prev_done;
  bit         m_active;
  int         m_k;
  logic       m_buzz;

  initial begin
    seg_tbl[0] = 7'h3F; seg_tbl[1] = 7'h06; seg_tbl[2] = 7'h5B; seg_tbl[3] = 7'h4F;
    seg_tbl[4] = 7'h66; seg_tbl[5] = 7'h6D; seg_tbl[6] = 7'h7D; seg_tbl[7] = 7'h07;
    seg_tbl[8] = 7'h7F; seg_tbl[9] = 7'h6F;
    for (int i = 10; i < 16; i++) seg_tbl[i] = 7'h00;
  end

  always @(posedge clk) begin
    m_ticked = 1'b0;
    if (clr) begin
      m_n = 0; m_slot = -1;
      m_seg = 7'h00; m_an = 6'b111111; m_dp = 1'b0;
      for (int i = 0; i < 6; i++) m_snap[i] = 4'd0;
      m_prev_done = 1'b0; m_active = 1'b0; m_k = 0; m_buzz = 1'b0;
    end else begin
      bit blank;
      bit rise;
      m_n++;
      if (m_n % SCAN_DIV == 0) begin
        m_ticked = 1'b1;
        m_slot = (m_n / SCAN_DIV - 1) % 6;
        if (m_slot == 0) begin
          m_snap[0] = s_l; m_snap[1] = s_h; m_snap[2] = m_l;
          m_snap[3] = m_h; m_snap[4] = h_l; m_snap[5] = h_h;
        end
        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        blank = (m_slot == 5 && m_snap[5] == 0) ||
                (m_slot == 4 && m_snap[5] == 0 && m_snap[4] == 0);
`endif
        m_seg = blank ? 7'h00 : seg_tbl[m_snap[m_slot]];
        m_an  = 6'b111111;
        m_an[m_slot] = 1'b0;
        m_dp  = (m_slot == 2 || m_slot == 4);
      end
      // beep: k = edges since the last rising edge of done
      rise = done && !m_prev_done;
      m_prev_done = done;
      if (rise) begin
        m_active = 1'b1; m_k = 0;
      end else if (m_active) begin
        m_k++;
        if (m_k >= BEEP_LEN) m_active = 1'b0;
      end
      m_buzz = m_active && (m_k < BEEP_LEN) && (((m_k / TONE_DIV) % 2) == 1);
    end
  end

  // ---------------- scoreboard ----------------
  int n_asserts = 0;
  int n_fail    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("an",   32'(an),   32'(m_an));
    chk("seg",  32'(seg),  32'(m_seg));
    chk("dp",   32'(dp),   32'(m_dp));
    chk("buzz", 32'(buzz), 32'(m_buzz));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_outputs();
    end
  endtask

  task automatic set_time(input logic [3:0] a, b, c, d, e, f);
    h_h = a; h_l = b; m_h = c; m_l = d; s_h = e; s_l = f;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit seen;
    set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);

    // reset held for 3 cycles
    step(3);
    chk("rst_an",   32'(an),   32'h3F);
    chk("rst_seg",  32'(seg),  32'h00);
    chk("rst_dp",   32'(dp),   32'h0);
    chk("rst_buzz", 32'(buzz), 32'h0);
    clr = 1'b0;

    // dark for the first three edges, slot 0 on the fourth
    step(3);
    chk("dark_an", 32'(an), 32'h3F);
    step(1);
    chk("slot0_an",  32'(an),  32'b111110);
    chk("slot0_seg", 32'(seg), 32'h7D);
    step(SCAN_DIV);
    chk("slot1_seg", 32'(seg), 32'h6D);
    step(SCAN_DIV);
    chk("slot2_dp",  32'(dp),  32'h1);
    step(SCAN_DIV * 3);
    chk("slot5_an",  32'(an),  32'b011111);
    chk("slot5_seg", 32'(seg), 32'h06);

    // S_l change in slot 3 only appears at the next slot 0
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(1);
      if (m_ticked && m_slot == 3) seen = 1'b1;
    end
    chk("reach_slot3", 32'(seen), 32'h1);
    s_l = 4'd7;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(1);
      if (m_ticked && m_slot == 0) seen = 1'b1;
    end
    chk("reach_slot0", 32'(seen), 32'h1);
    chk("sl_new_seg", 32'(seg), 32'h07);

    // invalid BCD on M_h blanks slot 3 but the enable still cycles
    m_h = 4'hB;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step(1);
      if (m_ticked && m_slot == 3 && m_snap[3] == 4'hB) seen = 1'b1;
    end
    chk("reach_bad", 32'(seen), 32'h1);
    chk("bad_seg", 32'(seg), 32'h00);
    chk("bad_an",  32'(an),  32'b110111);

    // beep: hold done, no retrigger while level stays high
    done = 1'b1; step(BEEP_LEN + 6);
    chk("beep_quiet", 32'(buzz), 32'h0);
    step(8);
    done = 1'b0; step(2);
    done = 1'b1; step(BEEP_LEN + 3);
    // re-raise 5 cycles into a beep
    done = 1'b0; step(1);
    done = 1'b1; step(5);
    done = 1'b0; step(1);
    done = 1'b1; step(BEEP_LEN + 3);
    // clear mid-beep
    done = 1'b0; step(1);
    done = 1'b1; step(4);
    clr = 1'b1; step(1);
    chk("clr_buzz", 32'(buzz), 32'h0);
    chk("clr_an",   32'(an),   32'h3F);
    clr = 1'b0; done = 1'b0;

    // leading zeros 00:05:09
    set_time(4'd0, 4'd0, 4'd0, 4'd5, 4'd0, 4'd9);
    step(SCAN_DIV * 6 * 2 + 2);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(1);
      if (m_ticked && m_slot == 4) seen = 1'b1;
    end
    chk("reach_lz", 32'(seen), 32'h1);
    chk("lz_dp4", 32'(dp), 32'h1);
`ifdef LEADING_ZERO_BLANK_EN
    chk("lz_seg4", 32'(seg), 32'h00);
`else
    chk("lz_seg4", 32'(seg), 32'h3F);
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 5))
          0: h_h = 4'($urandom_range(0, 15));
          1: h_l = 4'($urandom_range(0, 15));
          2: m_h = 4'($urandom_range(0, 15));
          3: m_l = 4'($urandom_range(0, 15));
          4: s_h = 4'($urandom_range(0, 15));
          default: s_l = 4'($urandom_range(0, 15));
        endcase
      end
      if ($urandom_range(0, 7) == 0) done = ~done;
      clr = ($urandom_range(0, 199) == 0);
      step(1);
    end
    clr = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
